// File: rtl/program_loader_if.sv
// ============================================================================
// Module   : program_loader_if
// Purpose  : Byte-stream valid/ready channel from the host to the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Loads length/words/checksum byte stream into instruction memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start_i,
  program_loader_if.slave            byte_if,
  output logic [ADDR_WIDTH-1:0]      imem_addr_o,
  output logic [DATA_WIDTH-1:0]      imem_data_o,
  output logic                       imem_we_o,
  output logic                       cpu_hold_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [1:0]                 error_code_o,
  output logic [ADDR_WIDTH:0]        word_count_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] C_TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_LO    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  localparam logic [1:0] C_ERR_NONE  = 2'b00;
  localparam logic [1:0] C_ERR_CSUM  = 2'b01;
  localparam logic [1:0] C_ERR_TOUT  = 2'b10;

  logic [2:0]            state_q, state_d;
  logic [7:0]            len_q;
  logic [7:0]            csum_q;
  logic [TW-1:0]         tout_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [1:0]            ecode_q;

  logic                  w_ready;
  logic                  w_xfer;
  logic                  w_start_ok;
  logic                  w_waiting;
  logic                  w_tout_hit;
  logic [ADDR_WIDTH:0]   w_count_inc;

  assign w_xfer      = byte_if.byte_valid & w_ready;
  assign w_start_ok  = start_i & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign w_waiting   = (state_q == S_HI) | (state_q == S_LO) | (state_q == S_CSUM);
  assign w_tout_hit  = w_waiting & ~w_xfer & (tout_q == C_TOUT_LAST);
  assign w_count_inc = count_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_ok) state_d = S_LEN;
      end
      S_LEN: begin
        if (w_xfer) state_d = (byte_if.byte_in == 8'h00) ? S_CSUM : S_HI;
      end
      S_HI: begin
        if (w_xfer)          state_d = S_LO;
        else if (w_tout_hit) state_d = S_ERROR;
      end
      S_LO: begin
        if (w_xfer)          state_d = S_WRITE;
        else if (w_tout_hit) state_d = S_ERROR;
      end
      S_WRITE: begin
        state_d = (w_count_inc == (ADDR_WIDTH+1)'(len_q)) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (w_xfer)          state_d = (byte_if.byte_in == csum_q) ? S_DONE : S_ERROR;
        else if (w_tout_hit) state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready    = w_waiting | (state_q == S_LEN);
    imem_we_o  = (state_q == S_WRITE);
    done_o     = (state_q == S_DONE);
    error_o    = (state_q == S_ERROR);
    cpu_hold_o = (state_q != S_DONE);
  end

  assign byte_if.byte_ready = w_ready;
  assign imem_addr_o        = addr_q;
  assign imem_data_o        = data_q;
  assign error_code_o       = ecode_q;
  assign word_count_o       = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      csum_q  <= '0;
      tout_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      ecode_q <= C_ERR_NONE;
    end else begin
      // Idle counter only runs while a byte is owed and none arrives.
      if (w_waiting && !w_xfer) tout_q <= tout_q + 1'b1;
      else                      tout_q <= '0;

      if (w_start_ok) begin
        csum_q  <= '0;
        addr_q  <= '0;
        count_q <= '0;
        ecode_q <= C_ERR_NONE;
      end

      case (state_q)
        S_LEN: if (w_xfer) len_q <= byte_if.byte_in;
        S_HI: if (w_xfer) begin
          data_q[15:8] <= byte_if.byte_in;
          csum_q       <= csum_q ^ byte_if.byte_in;
        end
        S_LO: if (w_xfer) begin
          data_q[7:0] <= byte_if.byte_in;
          csum_q      <= csum_q ^ byte_if.byte_in;
        end
        S_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          count_q <= w_count_inc;
        end
        S_CSUM: if (w_xfer && byte_if.byte_in != csum_q) ecode_q <= C_ERR_CSUM;
        default: ;
      endcase

      if (w_tout_hit) ecode_q <= C_ERR_TOUT;
    end
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart to the processor's instruction fetch. Receives a byte stream (length, instruction words, checksum) over a valid/ready interface and writes 16-bit words into instruction memory from address 0.
- Holds the processor via cpu_hold until a load passes its checksum.
- Sits between the host/bench byte source and the instruction memory write port.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width (matches 8-bit PC).
- DATA_WIDTH, 16, instruction word width; fixed at 16 (two bytes per word).
- TIMEOUT_CYCLES, 1024, maximum idle cycles waiting for a byte mid-load before aborting.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERROR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_addr  output  ADDR_WIDTH  instruction memory write address.
- imem_data  output  16  instruction word to write.
- imem_we  output  1  write strobe; one cycle per word.
- cpu_hold  output  1  1 means the processor is stalled.
- done  output  1  load completed with a good checksum.
- error  output  1  load aborted.
- error_code  output  2  01 = checksum mismatch, 10 = timeout, 00 = none.
- word_count  output  ADDR_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - byte_ready=0, imem_we=0, imem_addr=0, imem_data=0.
  - cpu_hold=1, done=0, error=0, error_code=00, word_count=0.
  - Internal length, checksum and timeout counters are cleared.
- Byte transfer: a byte is transferred on a rising edge with byte_valid & byte_ready.
- byte_ready is 1 only in states LEN, HI, LO and CSUM. It is combinational from state.
- IDLE:
  - On start: go to LEN; cpu_hold=1; clear done, error, error_code, word_count, imem_addr, checksum.
- LEN:
  - Accept byte N = number of words, 0..255.
  - N=0: go to CSUM.
  - Otherwise go to HI.
- HI: accept the high byte into imem_data[15:8]; go to LO.
- LO: accept the low byte into imem_data[7:0]; go to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1 with current imem_addr and imem_data.
  - Next edge: imem_addr+1, word_count+1.
  - If word_count+1 == N, go to CSUM; else go to HI.
  - Latency: a word is written on the cycle immediately after its low byte is accepted.
- Checksum:
  - Running checksum = XOR of all HI and LO data bytes. The length byte is excluded.
  - Initial value 0x00.
- CSUM:
  - Accept the checksum byte.
  - Equal to the running checksum: go to DONE.
  - Otherwise go to ERROR with error_code=01.
- DONE: done=1, cpu_hold=0; held until start or rst.
- ERROR: error=1, cpu_hold=1; held until start or rst.
- start in DONE/ERROR: behaves as start in IDLE, with the same clears, and goes to LEN.
- start in LEN, HI, LO, WRITE or CSUM is ignored.
- Timeout:
  - In HI, LO and CSUM, a counter increments on every cycle without a transfer and clears on a transfer.
  - On reaching TIMEOUT_CYCLES, go to ERROR with error_code=10.
  - LEN never times out.
- imem_addr wrap: N ≤ 255, so imem_addr never wraps within a load.
- Reset mid-load: returns to IDLE immediately. Words already written stay in memory. cpu_hold=1.
- byte_valid while byte_ready=0 is ignored; no byte is consumed.

Test Plan:
- Normal load: start; stream 02, 12, 34, AB, CD, checksum 0x12^0x34^0xAB^0xCD=0x40.
  - Expect imem_we at addr 0 with data 0x1234, then addr 1 with data 0xABCD.
  - Then done=1, cpu_hold=0, word_count=2.
- Bad checksum: same stream with checksum 0x41 → error=1, error_code=01, cpu_hold=1, done=0.
- Zero length: start; stream 00, 00 → no imem_we, done=1, word_count=0.
- Timeout:
  - With TIMEOUT_CYCLES=16: stream 01, 55, then hold byte_valid=0 for 16 cycles.
  - Expect error_code=10, no imem_we.
- Backpressure and ignored start:
  - Drive byte_valid with gaps of 3 cycles and pulse start mid-load.
  - Expect the load result identical to the normal-load case.
- Reset mid-load: assert rst between HI and LO of word 1.
  - Expect all outputs at reset values immediately.
  - A subsequent start plus a full stream completes with done=1.
